// File: rtl/fifo_v4.sv
// fifo_v4: single-clock parametrised FIFO with occupancy count, programmable
// almost-full/almost-empty flags and overflow/underflow reporting.
// Optional macro FIFO_V4_STICKY_ERR_EN: sticky error flags cleared by err_clr_i.
module fifo_v4 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic [DATA_WIDTH-1:0],
    parameter int unsigned CNT_WIDTH    = $clog2(DEPTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
`ifdef FIFO_V4_STICKY_ERR_EN
    input  logic                 err_clr_i,
`endif
    input  dtype                 data_i,
    input  logic                 push_i,
    output dtype                 data_o,
    input  logic                 pop_i,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [CNT_WIDTH-1:0] usage_o,
    input  logic [CNT_WIDTH-1:0] afull_thresh_i,
    input  logic [CNT_WIDTH-1:0] aempty_thresh_i,
    output logic                 afull_o,
    output logic                 aempty_o,
    output logic                 overflow_o,
    output logic                 underflow_o
);

    localparam int unsigned          PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_WIDTH-1:0] LAST_PTR  = PTR_WIDTH'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT  = CNT_WIDTH'(DEPTH);

    generate
        if (DEPTH == 0 || DEPTH > 65536) begin : g_depth_check
            $error("fifo_v4: DEPTH must be in 1..65536");
        end
    endgenerate

    dtype                 mem [DEPTH];
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [CNT_WIDTH-1:0] count;

    logic cnt_zero;
    logic bypass_visible;
    logic bypass;
    logic pop_ok;
    logic push_ok;
    logic do_pop;
    logic do_push;
    logic overflow_event;
    logic underflow_event;

    // Wrap explicitly so non-power-of-two depths never index past DEPTH-1.
    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_WIDTH'(1);
    endfunction

    assign cnt_zero       = (count == '0);
    assign full_o         = (count == FULL_CNT);
    assign bypass_visible = FALL_THROUGH && cnt_zero && push_i;
    assign empty_o        = cnt_zero && !bypass_visible;
    assign bypass         = bypass_visible && pop_i;

    // When full, a same-cycle pop frees the head slot, which is where wr_ptr points.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_i);
    assign do_pop  = pop_ok && !bypass;
    assign do_push = push_ok && !bypass;

    assign overflow_event  = push_i && full_o && !pop_i && !flush_i;
    assign underflow_event = pop_i && empty_o && !flush_i;

    assign data_o   = bypass_visible ? data_i : mem[rd_ptr];
    assign usage_o  = count;
    assign afull_o  = (count >= afull_thresh_i);
    assign aempty_o = (count <= aempty_thresh_i);

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_WIDTH'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !rst_i && !flush_i) begin
            mem[wr_ptr] <= data_i;
        end
    end

`ifdef FIFO_V4_STICKY_ERR_EN
    // A new event takes precedence over a same-cycle clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (overflow_event) begin
                overflow_o <= 1'b1;
            end else if (err_clr_i) begin
                overflow_o <= 1'b0;
            end
            if (underflow_event) begin
                underflow_o <= 1'b1;
            end else if (err_clr_i) begin
                underflow_o <= 1'b0;
            end
        end
    end
`else
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            overflow_o  <= overflow_event;
            underflow_o <= underflow_event;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_v4.sv
// tb_fifo_v4: table-driven and scoreboard checks of fifo_v4 at DEPTH 4, 3
// (non-power-of-two) and 8 with fall-through, all sharing one stimulus stream.
module tb_fifo_v4;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        int cnt;
        bit ovf;
        bit unf;
    } mstate_t;

    typedef struct {
        logic       push;
        logic       pop;
        logic       flush;
        logic [7:0] din;
        int         usage;
        logic       full;
        logic       empty;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       push;
    logic       pop;
    logic [7:0] din;
`ifdef FIFO_V4_STICKY_ERR_EN
    logic       err_clr = 1'b0;
`endif

    logic [7:0] a_dout, b_dout, c_dout;
    logic       a_full, b_full, c_full;
    logic       a_empty, b_empty, c_empty;
    logic [2:0] a_usage, a_afth, a_aeth;
    logic [1:0] b_usage, b_afth, b_aeth;
    logic [3:0] c_usage, c_afth, c_aeth;
    logic       a_af, b_af, c_af, a_ae, b_ae, c_ae;
    logic       a_ovf, b_ovf, c_ovf, a_unf, b_unf, c_unf;

    int checks = 0;
    int errors = 0;

    mstate_t sa = '{0, 1'b0, 1'b0};
    mstate_t sb = '{0, 1'b0, 1'b0};
    mstate_t sc = '{0, 1'b0, 1'b0};
    bq_t     qa, qb, qc;
    vec_t    tbl [17];

    always #5 clk = ~clk;

    fifo_v4 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(4)) dut_a (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
`ifdef FIFO_V4_STICKY_ERR_EN
        .err_clr_i(err_clr),
`endif
        .data_i(din), .push_i(push), .data_o(a_dout), .pop_i(pop),
        .full_o(a_full), .empty_o(a_empty), .usage_o(a_usage),
        .afull_thresh_i(a_afth), .aempty_thresh_i(a_aeth),
        .afull_o(a_af), .aempty_o(a_ae), .overflow_o(a_ovf), .underflow_o(a_unf)
    );

    fifo_v4 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(3)) dut_b (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
`ifdef FIFO_V4_STICKY_ERR_EN
        .err_clr_i(err_clr),
`endif
        .data_i(din), .push_i(push), .data_o(b_dout), .pop_i(pop),
        .full_o(b_full), .empty_o(b_empty), .usage_o(b_usage),
        .afull_thresh_i(b_afth), .aempty_thresh_i(b_aeth),
        .afull_o(b_af), .aempty_o(b_ae), .overflow_o(b_ovf), .underflow_o(b_unf)
    );

    fifo_v4 #(.FALL_THROUGH(1'b1), .DATA_WIDTH(8), .DEPTH(8)) dut_c (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
`ifdef FIFO_V4_STICKY_ERR_EN
        .err_clr_i(err_clr),
`endif
        .data_i(din), .push_i(push), .data_o(c_dout), .pop_i(pop),
        .full_o(c_full), .empty_o(c_empty), .usage_o(c_usage),
        .afull_thresh_i(c_afth), .aempty_thresh_i(c_aeth),
        .afull_o(c_af), .aempty_o(c_ae), .overflow_o(c_ovf), .underflow_o(c_unf)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference behaviour of one FIFO for the current inputs.
    function automatic mstate_t mnext(input mstate_t s, input int depth, input bit ft);
        mstate_t n = s;
        bit m_full  = (s.cnt == depth);
        bit m_empty = (s.cnt == 0) && !(ft && push);
        bit pok     = pop && !m_empty;
        bit wok     = push && (!m_full || pop);
        bit byp     = ft && (s.cnt == 0) && push && pop;
        bit oe      = push && m_full && !pop && !flush;
        bit ue      = pop && m_empty && !flush;
        if (rst) begin
            n.cnt = 0;
            n.ovf = 1'b0;
            n.unf = 1'b0;
            return n;
        end
        if (flush) n.cnt = 0;
        else if (!byp) n.cnt = s.cnt + (wok ? 1 : 0) - (pok ? 1 : 0);
`ifdef FIFO_V4_STICKY_ERR_EN
        n.ovf = oe ? 1'b1 : (err_clr ? 1'b0 : s.ovf);
        n.unf = ue ? 1'b1 : (err_clr ? 1'b0 : s.unf);
`else
        n.ovf = oe;
        n.unf = ue;
`endif
        return n;
    endfunction

    task automatic pre_chk(input string nm, input mstate_t s, input int depth, input bit ft,
                           input bq_t qi, output bq_t qo, input logic [7:0] dout,
                           input logic full, input logic empty, input logic af,
                           input logic ae, input int afth, input int aeth);
        bit m_full  = (s.cnt == depth);
        bit m_empty = (s.cnt == 0) && !(ft && push);
        bit pok     = pop && !m_empty;
        bit wok     = push && (!m_full || pop);
        bit byp     = ft && (s.cnt == 0) && push && pop;
        qo = qi;
        if (!rst) begin
            chk({nm, " full"}, full, m_full);
            chk({nm, " empty"}, empty, m_empty);
            chk({nm, " afull"}, af, s.cnt >= afth);
            chk({nm, " aempty"}, ae, s.cnt <= aeth);
            if (ft && s.cnt == 0 && push) chk({nm, " fallthru data"}, dout, din);
            else if (pok) begin
                if (qo.size() > 0) chk({nm, " pop data"}, dout, qo[0]);
                else chk({nm, " scoreboard underrun"}, 1, 0);
            end
        end
        if (rst || flush) qo.delete();
        else begin
            if (pok && !byp) void'(qo.pop_front());
            if (wok && !byp) qo.push_back(din);
        end
    endtask

    task automatic post_chk(input string nm, input mstate_t s, input int depth,
                            input int usage, input logic ovf, input logic unf);
        chk({nm, " usage"}, usage, s.cnt);
        chk({nm, " usage bound"}, usage <= depth, 1);
        chk({nm, " overflow"}, ovf, s.ovf);
        chk({nm, " underflow"}, unf, s.unf);
    endtask

    task automatic step();
        mstate_t na, nb, nc;
        #1;
        na = mnext(sa, 4, 1'b0);
        nb = mnext(sb, 3, 1'b0);
        nc = mnext(sc, 8, 1'b1);
        pre_chk("a", sa, 4, 1'b0, qa, qa, a_dout, a_full, a_empty, a_af, a_ae, a_afth, a_aeth);
        pre_chk("b", sb, 3, 1'b0, qb, qb, b_dout, b_full, b_empty, b_af, b_ae, b_afth, b_aeth);
        pre_chk("c", sc, 8, 1'b1, qc, qc, c_dout, c_full, c_empty, c_af, c_ae, c_afth, c_aeth);
        @(posedge clk);
        #1;
        sa = na;
        sb = nb;
        sc = nc;
        post_chk("a", sa, 4, a_usage, a_ovf, a_unf);
        post_chk("b", sb, 3, b_usage, b_ovf, b_unf);
        post_chk("c", sc, 8, c_usage, c_ovf, c_unf);
    endtask

    task automatic drive(input logic p_push, input logic p_pop, input logic p_flush,
                         input logic [7:0] p_din);
        push  = p_push;
        pop   = p_pop;
        flush = p_flush;
        din   = p_din;
        step();
    endtask

    initial begin
        tbl = '{
            '{1'b1, 1'b0, 1'b0, 8'h11, 1, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b0, 8'h22, 2, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b0, 8'h33, 3, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b0, 8'h44, 4, 1'b1, 1'b0},
            '{1'b0, 1'b1, 1'b0, 8'h00, 3, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 8'h00, 2, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 8'h00, 1, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1},
            '{1'b1, 1'b0, 1'b0, 8'hA0, 1, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b0, 8'hA1, 2, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b0, 8'hA2, 3, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b0, 8'hA3, 4, 1'b1, 1'b0},
            '{1'b1, 1'b1, 1'b0, 8'hB0, 4, 1'b1, 1'b0},
            '{1'b0, 1'b1, 1'b0, 8'h00, 3, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 8'h00, 2, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 8'h00, 1, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1}
        };

        rst = 1'b1; flush = 1'b0; push = 1'b0; pop = 1'b0; din = 8'h00;
        a_afth = 3'd3; a_aeth = 3'd1;
        b_afth = 2'd2; b_aeth = 2'd0;
        c_afth = 4'd6; c_aeth = 4'd1;
        step();
        step();
        rst = 1'b0;
        chk("reset usage", a_usage, 0);
        chk("reset empty", a_empty, 1);
        chk("reset full", a_full, 0);
        chk("reset aempty", a_ae, 1);

        // Fill/drain, then push+pop while full; data order comes from the scoreboard.
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].push, tbl[i].pop, tbl[i].flush, tbl[i].din);
            chk($sformatf("tbl%0d usage", i), a_usage, tbl[i].usage);
            chk($sformatf("tbl%0d full", i), a_full, tbl[i].full);
            chk($sformatf("tbl%0d empty", i), a_empty, tbl[i].empty);
            chk($sformatf("tbl%0d no overflow", i), a_ovf, 0);
        end
`ifdef FIFO_V4_STICKY_ERR_EN
        err_clr = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        err_clr = 1'b0;
`endif

        // Non-power-of-two wrap on the depth-3 instance, including push+pop while full.
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        for (int v = 1; v <= 3; v++) drive(1'b1, 1'b0, 1'b0, 8'(v));
        for (int v = 4; v <= 10; v++) begin
            drive(1'b1, 1'b1, 1'b0, 8'(v));
            chk($sformatf("wrap usage v%0d", v), b_usage, 3);
        end
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 8'h00);
        chk("wrap drained", b_empty, 1);

        // Fall-through bypass on the empty depth-8 instance.
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        push = 1'b1; pop = 1'b1; din = 8'h5A;
        #1;
        chk("ft same-cycle data", c_dout, 8'h5A);
        chk("ft same-cycle empty", c_empty, 0);
        step();
        chk("ft bypass usage", c_usage, 0);
        drive(1'b1, 1'b0, 1'b0, 8'h01);
        drive(1'b1, 1'b0, 1'b0, 8'h02);
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        chk("ft after bypass empty", c_empty, 1);

        // Thresholds on the depth-8 instance.
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'(8'h80 + i));
            chk($sformatf("afull at %0d", i), c_af, i >= 6);
            chk($sformatf("aempty at %0d", i), c_ae, i <= 1);
        end
        push = 1'b0;
        c_afth = 4'd9;
        #1;
        chk("afull thresh above depth", c_af, 0);
        chk("full at 8", c_full, 1);
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        c_afth = 4'd6;
`ifdef FIFO_V4_STICKY_ERR_EN
        err_clr = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        err_clr = 1'b0;
`endif

        // Overflow on the depth-4 instance.
        for (int v = 0; v < 4; v++) drive(1'b1, 1'b0, 1'b0, 8'(8'hC0 + v));
        drive(1'b1, 1'b0, 1'b0, 8'hCC);
        chk("overflow raised", a_ovf, 1);
        chk("overflow usage held", a_usage, 4);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
`ifdef FIFO_V4_STICKY_ERR_EN
        chk("overflow sticky", a_ovf, 1);
        err_clr = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 8'hCD);
        chk("event beats clear", a_ovf, 1);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        err_clr = 1'b0;
        chk("overflow cleared", a_ovf, 0);
`else
        chk("overflow pulse ends", a_ovf, 0);
`endif

        // Flush while full with a push: no overflow, count cleared.
        drive(1'b1, 1'b0, 1'b1, 8'hEE);
        chk("flush usage", a_usage, 0);
        chk("flush no overflow", a_ovf, 0);
        chk("flush no underflow", a_unf, 0);

        // Underflow.
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        chk("underflow raised", a_unf, 1);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
`ifdef FIFO_V4_STICKY_ERR_EN
        chk("underflow sticky", a_unf, 1);
        err_clr = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        err_clr = 1'b0;
        chk("underflow cleared", a_unf, 0);
`else
        chk("underflow pulse ends", a_unf, 0);
`endif

        // Flush with partial content and a push.
        drive(1'b1, 1'b0, 1'b0, 8'h71);
        drive(1'b1, 1'b0, 1'b0, 8'h72);
        drive(1'b1, 1'b1, 1'b1, 8'h73);
        chk("partial flush usage", a_usage, 0);
        chk("partial flush empty", a_empty, 1);
        drive(1'b0, 1'b0, 1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
